// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//
// Shares the single read port and single write port of register_file among
// NREQ execution-unit requesters (0 = branch, then data-processing,
// load/store and debug/bench). A granted requester locks both ports until
// it drops req. Ownership rotates round-robin, and a hold limit preempts an
// owner that has kept the ports for MAX_HOLD cycles while someone else waits.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   req              per-requester ownership request (held for a transaction)
//   gnt              one-hot grant, all zero when idle
//   req_read_en      per-requester read strobe
//   req_read_reg     flattened read indices, requester i at [i*RW +: RW]
//   req_write_en     per-requester write strobe
//   req_write_reg    flattened write indices
//   req_write_value  flattened write data, requester i at [i*DW +: DW]
//   rd_value         read data broadcast to all requesters
//   rd_valid         one-hot, marks the requester rd_value belongs to
//   rf_read_en/rf_read_reg/rf_read_value     register_file read port
//   rf_write_en/rf_write_reg/rf_write_value  register_file write port

module regfile_port_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 32,
    parameter int RW       = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    input  logic [NREQ-1:0]      req_read_en,
    input  logic [NREQ*RW-1:0]   req_read_reg,
    input  logic [NREQ-1:0]      req_write_en,
    input  logic [NREQ*RW-1:0]   req_write_reg,
    input  logic [NREQ*DW-1:0]   req_write_value,
    output logic [DW-1:0]        rd_value,
    output logic [NREQ-1:0]      rd_valid,
    output logic                 rf_read_en,
    output logic [RW-1:0]        rf_read_reg,
    input  logic [DW-1:0]        rf_read_value,
    output logic                 rf_write_en,
    output logic [RW-1:0]        rf_write_reg,
    output logic [DW-1:0]        rf_write_value
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [IW-1:0] LAST_AT_RESET = IW'(NREQ - 1);
    localparam logic [HW-1:0] HOLD_LIMIT    = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT      = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   owner, owner_next;
    logic [IW-1:0]   last, last_next;
    logic [HW-1:0]   hold, hold_next;
    logic            pend_valid;
    logic [IW-1:0]   pend_id;

    logic [IW-1:0]   sel;
    logic            sel_found;
    logic [NREQ-1:0] owner_onehot;
    logic [NREQ-1:0] others_req;
    logic            granted;
    logic            preempt;

    assign owner_onehot = NREQ'(1) << owner;
    assign others_req   = req & ~owner_onehot;
    assign granted      = (state == GRANT) && !rst;
    assign gnt          = (state == GRANT) ? owner_onehot : '0;

    // The hold limit is compared with >= rather than == so that an owner
    // that ran alone long enough for the counter to saturate is still
    // preempted as soon as a competitor shows up.
    assign preempt = (hold >= HOLD_LIMIT) && (|others_req);

    // Round-robin pick: first requesting index after the last owner, with
    // wrap, so the previous owner is considered last.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!sel_found && req[(int'(last) + k) % NREQ]) begin
                sel_found = 1'b1;
                sel       = IW'((int'(last) + k) % NREQ);
            end
        end
    end

    // Port mux: the owner's request fields drive register_file directly.
    // Everything is forced to zero while idle or in reset, so a strobe in
    // the reset cycle never reaches the register file.
    always_comb begin
        rf_read_en     = 1'b0;
        rf_read_reg    = '0;
        rf_write_en    = 1'b0;
        rf_write_reg   = '0;
        rf_write_value = '0;
        if (granted) begin
            rf_read_reg    = req_read_reg[int'(owner)*RW +: RW];
            rf_write_reg   = req_write_reg[int'(owner)*RW +: RW];
            rf_write_value = req_write_value[int'(owner)*DW +: DW];
            rf_read_en     = gnt[owner] && req[owner] && req_read_en[owner];
            rf_write_en    = gnt[owner] && req[owner] && req_write_en[owner];
        end
    end

    // Read return: register_file data arrives one cycle after read_en, so
    // the requester tag is carried in pend_id and released independently
    // of whether the grant is still held.
    always_comb begin
        rd_valid = '0;
        rd_value = '0;
        if (pend_valid && !rst) begin
            rd_valid = NREQ'(1) << pend_id;
            rd_value = rf_read_value;
        end
    end

    // Next-state: grant from IDLE, release or preempt from GRANT. Both exits
    // record the owner as last so it drops to lowest priority.
    always_comb begin
        state_next = state;
        owner_next = owner;
        last_next  = last;
        hold_next  = hold;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = GRANT;
                    owner_next = sel;
                    hold_next  = '0;
                end
            end
            GRANT: begin
                if (!req[owner] || preempt) begin
                    state_next = IDLE;
                    last_next  = owner;
                    hold_next  = '0;
                end else if (hold != HOLD_SAT) begin
                    hold_next = hold + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last       <= LAST_AT_RESET;
            hold       <= '0;
            pend_valid <= 1'b0;
            pend_id    <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last       <= last_next;
            hold       <= hold_next;
            pend_valid <= rf_read_en;
            pend_id    <= owner;
        end
    end

endmodule
